// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: core count, FSM states,
// and the active-core clamp and mask functions.
package dmem_arb_pkg;

  localparam int unsigned NCORE = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // A core count of 0 means 1; anything above NCORE saturates.
  function automatic logic [2:0] clamp_noc(input logic [2:0] n);
    if (n == 3'd0) begin
      return 3'd1;
    end else if (n > 3'(NCORE)) begin
      return 3'(NCORE);
    end else begin
      return n;
    end
  endfunction

  function automatic logic [NCORE-1:0] core_mask(input logic [2:0] n);
    core_mask = '0;
    for (int unsigned i = 0; i < NCORE; i++) begin
      if (3'(i) < n) begin
        core_mask[i] = 1'b1;
      end
    end
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [NCORE-1:0] oh);
    onehot_idx = '0;
    for (int unsigned i = 0; i < NCORE; i++) begin
      if (oh[i]) begin
        onehot_idx = 2'(i);
      end
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first eligible core at or after the
// pointer, wrapping within the active core count.
module rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [NCORE-1:0] eligible,
  input  logic [1:0]       ptr,
  input  logic [2:0]       count,
  output logic [NCORE-1:0] winner,
  output logic             valid
);

  logic [2:0] start;
  logic [2:0] idx;

  always_comb begin
    // A stale pointer left over from a larger core count restarts at core 0.
    start  = ({1'b0, ptr} >= count) ? 3'd0 : {1'b0, ptr};
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NCORE; k++) begin
      idx = start + 3'(k);
      if (idx >= count) begin
        idx = idx - count;
      end
      if (!valid && (3'(k) < count) && eligible[idx[1:0]]) begin
        winner[idx[1:0]] = 1'b1;
        valid            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Four-core arbiter for a single shared data-memory port, one access in flight.
// Define DMEM_ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              noc,
  input  logic [NCORE-1:0]        req,
  input  logic [NCORE-1:0]        we,
  input  logic [NCORE*ADDR_W-1:0] addr,
  input  logic [NCORE*DATA_W-1:0] wdata,
  output logic [NCORE-1:0]        grant,
  output logic                    dmem_en,
  output logic                    dmem_we,
  output logic [ADDR_W-1:0]       dmem_addr,
  output logic [DATA_W-1:0]       dmem_wdata,
  input  logic [DATA_W-1:0]       dmem_rdata,
  output logic [NCORE-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    busy
);

  state_t            state;
  logic [1:0]        win_idx;
  logic              win_we;
  logic [2:0]        cnt;
  logic [2:0]        n_now;
  logic [NCORE-1:0]  eligible;
  logic [NCORE-1:0]  pick_oh;
  logic              pick_valid;
  logic [1:0]        pick_idx;
  logic [1:0]        ptr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic [1:0] rr_ptr;
  logic [2:0] n_lat;

  always_comb begin
    ptr = rr_ptr;
  end
`else
  always_comb begin
    ptr = '0;
  end
`endif

  always_comb begin
    n_now    = clamp_noc(noc);
    eligible = req & core_mask(n_now);
  end

  rr_pick u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .count    (n_now),
    .winner   (pick_oh),
    .valid    (pick_valid)
  );

  always_comb begin
    pick_idx  = onehot_idx(pick_oh);
    sel_addr  = addr[pick_idx*ADDR_W +: ADDR_W];
    sel_wdata = wdata[pick_idx*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      win_idx    <= '0;
      win_we     <= 1'b0;
      cnt        <= '0;
      grant      <= '0;
      dmem_en    <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rd_valid   <= '0;
      rd_data    <= '0;
      busy       <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      rr_ptr     <= '0;
      n_lat      <= '0;
`endif
    end else begin
      grant    <= '0;
      dmem_en  <= 1'b0;
      dmem_we  <= 1'b0;
      rd_valid <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            win_idx    <= pick_idx;
            win_we     <= we[pick_idx];
            dmem_addr  <= sel_addr;
            dmem_wdata <= sel_wdata;
            grant      <= pick_oh;
            dmem_en    <= 1'b1;
            dmem_we    <= we[pick_idx];
`ifndef DMEM_ARB_FIXED_PRIO_EN
            n_lat      <= n_now;
`endif
          end
        end
        ISSUE: begin
`ifndef DMEM_ARB_FIXED_PRIO_EN
          // Pointer wraps against the core count latched with this winner,
          // so a noc change mid-transaction only affects the next pick.
          if (({1'b0, win_idx} + 3'd1) >= n_lat) begin
            rr_ptr <= '0;
          end else begin
            rr_ptr <= win_idx + 2'd1;
          end
`endif
          if (win_we) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (RD_LAT == 1) begin
            state <= RESP;
          end else begin
            state <= WAIT;
            cnt   <= 3'(RD_LAT - 1);
          end
        end
        WAIT: begin
          // Leave on the step that takes the counter to zero so that RESP
          // lands exactly RD_LAT cycles after ISSUE.
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          state             <= IDLE;
          busy              <= 1'b0;
          rd_data           <= dmem_rdata;
          rd_valid[win_idx] <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected grants and read
// responses, a negedge monitor pops and compares whenever the DUT presents one.
module tb_dmem_arbiter;

  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    noc;
  logic [3:0]    req;
  logic [3:0]    we;
  logic [4*AW-1:0] addr;
  logic [4*DW-1:0] wdata;
  logic [3:0]    grant;
  logic          dmem_en;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic [3:0]    rd_valid;
  logic [DW-1:0] rd_data;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         at;
    logic [3:0] oh;
    logic       w;
    logic [15:0] a;
    logic [15:0] d;
  } gexp_t;

  typedef struct {
    int         at;
    logic [3:0] oh;
    logic [15:0] d;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  logic [15:0] mem [0:255];
  bit          mem_ok = 1'b0;
  logic [15:0] pipe0 = '0;
  logic [15:0] pipe1 = '0;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .noc        (noc),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .grant      (grant),
    .dmem_en    (dmem_en),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h5A00;
  endfunction

  // Memory model: two-stage read pipe, garbage outside the valid slot.
  always @(posedge clk) begin
    if (!mem_ok) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(16'(i));
      mem_ok <= 1'b1;
    end else if (dmem_en && dmem_we) begin
      mem[dmem_addr[7:0]] <= dmem_wdata;
    end
    pipe0 <= (dmem_en && !dmem_we) ? mem[dmem_addr[7:0]] : 16'hDEAD;
    pipe1 <= pipe0;
  end

  assign dmem_rdata = pipe1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic w, input logic [15:0] a, input logic [15:0] d);
    we[i]             = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic exp_grant(input int c, input logic w, input logic [15:0] a,
                           input logic [15:0] d, input int at);
    logic [3:0] oh;
    oh    = '0;
    oh[c] = 1'b1;
    gq.push_back('{at: at, oh: oh, w: w, a: a, d: d});
  endtask

  task automatic exp_rd(input int c, input logic [15:0] d, input int at);
    logic [3:0] oh;
    oh    = '0;
    oh[c] = 1'b1;
    rq.push_back('{at: at, oh: oh, d: d});
  endtask

  always @(negedge clk) begin : monitor
    gexp_t g;
    rexp_t r;
    if (grant != '0 || dmem_en) begin
      if (gq.size() == 0) begin
        chk("spurious_grant", {27'd0, dmem_en, grant}, 32'd0);
      end else begin
        g = gq.pop_front();
        chk("grant_cycle", cyc, g.at);
        chk("grant_onehot", 32'(grant), 32'(g.oh));
        chk("dmem_en", 32'(dmem_en), 32'd1);
        chk("dmem_we", 32'(dmem_we), 32'(g.w));
        chk("dmem_addr", 32'(dmem_addr), 32'(g.a));
        chk("dmem_wdata", 32'(dmem_wdata), 32'(g.d));
      end
    end
    if (rd_valid != '0) begin
      if (rq.size() == 0) begin
        chk("spurious_rd_valid", 32'(rd_valid), 32'd0);
      end else begin
        r = rq.pop_front();
        chk("rd_cycle", cyc, r.at);
        chk("rd_valid", 32'(rd_valid), 32'(r.oh));
        chk("rd_data", 32'(rd_data), 32'(r.d));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int k;
    rst   = 1'b1;
    noc   = 3'd4;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    tick(3);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_dmem_en", 32'(dmem_en), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_addr", 32'(dmem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // All four cores reading, held: grants rotate 0,1,2,3,0.
    for (int i = 0; i < 4; i++) set_core(i, 1'b0, 16'h0020 + 16'(i), 16'h0000);
    noc = 3'd4;
    req = 4'b1111;
    k   = cyc;
    for (int n = 0; n < 5; n++) begin
      exp_grant(n % 4, 1'b0, 16'h0020 + 16'(n % 4), 16'h0000, k + 1 + 4*n);
      exp_rd(n % 4, init_val(16'h0020 + 16'(n % 4)), k + 4 + 4*n);
    end
    tick(2);
    chk("busy_in_wait", 32'(busy), 32'd1);
    tick(16);
    req = '0;
    tick(4);
    chk("busy_after_reads", 32'(busy), 32'd0);

    // noc above 4 saturates; writes on cores 1 and 3 alternate.
    for (int i = 0; i < 4; i++) set_core(i, 1'b1, 16'h0040 + 16'(i), 16'h1000 + 16'(i));
    noc = 3'd7;
    req = 4'b1010;
    k   = cyc;
    exp_grant(1, 1'b1, 16'h0041, 16'h1001, k + 1);
    exp_grant(3, 1'b1, 16'h0043, 16'h1003, k + 3);
    exp_grant(1, 1'b1, 16'h0041, 16'h1001, k + 5);
    tick(5);
    req = '0;
    tick(3);

    // Pointer (now 2) is out of range for noc=2 and restarts at core 0.
    noc = 3'd2;
    req = 4'b0011;
    k   = cyc;
    exp_grant(0, 1'b1, 16'h0040, 16'h1000, k + 1);
    exp_grant(1, 1'b1, 16'h0041, 16'h1001, k + 3);
    tick(3);
    req = '0;
    tick(3);
`else
    // Fixed priority: core 0 wins every arbitration.
    set_core(0, 1'b1, 16'h0060, 16'hA000);
    set_core(1, 1'b1, 16'h0061, 16'hA001);
    set_core(3, 1'b1, 16'h0063, 16'hA003);
    noc = 3'd4;
    req = 4'b1011;
    k   = cyc;
    for (int n = 0; n < 4; n++) exp_grant(0, 1'b1, 16'h0060, 16'hA000, k + 1 + 2*n);
    tick(7);
    req = '0;
    tick(3);
`endif

    // Requests from cores outside noc are ignored entirely.
    noc = 3'd2;
    req = 4'b1100;
    for (int n = 0; n < 8; n++) begin
      tick(1);
      chk("masked_busy", 32'(busy), 32'd0);
      chk("masked_dmem_en", 32'(dmem_en), 32'd0);
    end
    req = '0;

    // Write then read-back through the memory model.
    noc = 3'd4;
    set_core(1, 1'b1, 16'h0010, 16'hBEEF);
    set_core(2, 1'b0, 16'h0010, 16'h0000);
    req = 4'b0010;
    k   = cyc;
    exp_grant(1, 1'b1, 16'h0010, 16'hBEEF, k + 1);
    exp_grant(2, 1'b0, 16'h0010, 16'h0000, k + 3);
    exp_rd(2, 16'hBEEF, k + 6);
    tick(1);
    req = 4'b0100;
    tick(2);
    req = '0;
    tick(5);

    // noc=0 behaves as a single core.
    for (int i = 0; i < 4; i++) set_core(i, 1'b1, 16'h0040 + 16'(i), 16'h1000 + 16'(i));
    noc = 3'd0;
    req = 4'b1111;
    k   = cyc;
    for (int n = 0; n < 3; n++) exp_grant(0, 1'b1, 16'h0040, 16'h1000, k + 1 + 2*n);
    tick(5);
    req = '0;
    tick(3);

    // Withdrawal and address/noc change after latching do not disturb the read.
    noc = 3'd4;
    set_core(3, 1'b0, 16'h0021, 16'h0000);
    req = 4'b1000;
    k   = cyc;
    exp_grant(3, 1'b0, 16'h0021, 16'h0000, k + 1);
    exp_rd(3, init_val(16'h0021), k + 4);
    tick(1);
    req = '0;
    set_core(3, 1'b0, 16'h0099, 16'h0000);
    noc = 3'd1;
    tick(5);

    // Reset during WAIT aborts the read and clears the pointer.
    noc = 3'd4;
    set_core(0, 1'b0, 16'h0022, 16'h0000);
    req = 4'b0001;
    k   = cyc;
    exp_grant(0, 1'b0, 16'h0022, 16'h0000, k + 1);
    tick(1);
    req = '0;
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'd0);
    chk("midrst_dmem_addr", 32'(dmem_addr), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);
    rst = 1'b0;
    set_core(0, 1'b1, 16'h0050, 16'h1234);
    set_core(1, 1'b1, 16'h0051, 16'h5678);
    req = 4'b0011;
    k   = cyc;
    exp_grant(0, 1'b1, 16'h0050, 16'h1234, k + 1);
    tick(1);
    req = '0;
    tick(6);

    chk("grant_queue_drained", gq.size(), 32'd0);
    chk("rd_queue_drained", rq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
